// File: rtl/vc_pin_bus.sv
// Multiplexed external-memory bus master: one address and one data word per request,
// moved over the 8-bit uio pads as byte phases, MSB first.
module vc_pin_bus #(
   parameter int PA      = 24,
   parameter int RV      = 16,
   parameter int TURN    = 1,
   parameter int WAIT    = 0,
   parameter int TIMEOUT = 64
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_write_i,
   input  logic [PA-1:0] req_addr_i,
   input  logic [RV-1:0] req_wdata_i,
   output logic          resp_valid_o,
   output logic          resp_err_o,
   output logic [RV-1:0] resp_rdata_o,
   output logic          pin_ale_o,
   output logic          pin_we_o,
   output logic          pin_re_o,
   input  logic          pin_wait_n_i,
   input  logic [7:0]    uio_in_i,
   output logic [7:0]    uio_out_o,
   output logic [7:0]    uio_oe_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_TURN, S_WAIT, S_RDATA, S_DONE
   } state_t;

   typedef struct packed {
      logic          write;
      logic [PA-1:0] addr;
      logic [RV-1:0] wdata;
   } req_t;

   localparam int         SW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SW-1:0] TO_L   = SW'(TIMEOUT);
   localparam logic [2:0] NA_LAST   = 3'(PA / 8 - 1);
   localparam logic [2:0] ND_LAST   = 3'(RV / 8 - 1);
   localparam logic [2:0] TURN_LAST = 3'(TURN - 1);
   localparam logic [2:0] WAIT_LAST = 3'(WAIT - 1);

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [SW-1:0] stall_q, stall_d;
   req_t          req_q, req_d;
   logic [RV-1:0] rsh_q, rsh_d;
   logic [RV-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          hold;
   logic          timeout;
   logic [RV-1:0] rsh_next;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         stall_q <= '0;
         req_q   <= '0;
         rsh_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         req_q   <= req_d;
         rsh_q   <= rsh_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Address and write data are shifted left so the outgoing byte is always the top one.
   assign hold     = !pin_wait_n_i && (state_q inside {S_WDATA, S_WAIT, S_RDATA});
   assign timeout  = (TIMEOUT != 0) && ((stall_q + SW'(1)) == TO_L);
   assign rsh_next = (rsh_q << 8) | RV'(uio_in_i);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_d = '0;
      req_d   = req_q;
      rsh_d   = rsh_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      if (hold) begin
         if (timeout) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            cnt_d   = '0;
         end else begin
            stall_d = stall_q + SW'(1);
         end
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               state_d = S_IDLE;
               if (req_valid_i) begin
                  req_d   = {req_write_i, req_addr_i, req_wdata_i};
                  cnt_d   = '0;
                  err_d   = 1'b0;
                  state_d = S_ADDR;
               end
            end
            S_ADDR: begin
               req_d.addr = req_q.addr << 8;
               if (cnt_q == NA_LAST) begin
                  cnt_d   = '0;
                  state_d = req_q.write ? S_WDATA : S_TURN;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_WDATA: begin
               req_d.wdata = req_q.wdata << 8;
               if (cnt_q == ND_LAST) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_TURN: begin
               if (cnt_q == TURN_LAST) begin
                  cnt_d   = '0;
                  state_d = (WAIT == 0) ? S_RDATA : S_WAIT;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_WAIT: begin
               if (cnt_q == WAIT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_RDATA;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_RDATA: begin
               rsh_d = rsh_next;
               if (cnt_q == ND_LAST) begin
                  cnt_d   = '0;
                  rdata_d = rsh_next;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Pad outputs follow the current phase only; a stall simply repeats the phase.
   always_comb begin
      pin_ale_o = 1'b0;
      pin_we_o  = 1'b0;
      pin_re_o  = 1'b0;
      uio_out_o = 8'h00;
      uio_oe_o  = 8'h00;
      case (state_q)
         S_ADDR: begin
            pin_ale_o = 1'b1;
            uio_oe_o  = 8'hFF;
            uio_out_o = req_q.addr[PA-1 -: 8];
         end
         S_WDATA: begin
            pin_we_o  = 1'b1;
            uio_oe_o  = 8'hFF;
            uio_out_o = req_q.wdata[RV-1 -: 8];
         end
         S_TURN, S_WAIT, S_RDATA: pin_re_o = 1'b1;
         default: ;
      endcase
   end

   assign req_ready_o  = (state_q == S_IDLE || state_q == S_DONE) && !reset_i;
   assign resp_valid_o = (state_q == S_DONE) && !reset_i;
   assign resp_err_o   = resp_valid_o && err_q;
   assign resp_rdata_o = rdata_q;

endmodule
